aes_cipher_core: RTL and testbench
==================================

// Module: aes_cipher_core
// PURPOSE
// - Iterative AES-128 encryption datapath, one round per accepted round key.
// - Consumes the round keys from the key-schedule block through its SelKey/En/Key/Ry
//   interface, and drives the KeySel/KeyEn request lines.
// - Takes one 128-bit plaintext block per Start and returns the ciphertext with a Done pulse.
// - Sits between the host I/O block (upstream) and the key schedule (sideways feed).
// PARAMETERS
// - NR        10   number of rounds; fixed for AES-128, and any other value is unsupported
// - KEY_WAIT  15   maximum cycles waited for KeyRy per round before the error abort
// PORTS
// - Clk     in   1    single clock; all state changes on posedge
// - Rst     in   1    synchronous, active-high reset
// - Start   in   1    one-cycle request; Din is sampled on the same edge
// - Din     in   128  plaintext; Din[127:120] = byte 0 (column-major AES state)
// - KeySel  out  4    round-key index requested (0..10), to the key schedule's SelKey
// - KeyEn   out  1    round-key request strobe, to the key schedule's En
// - KeyIn   in   128  round key returned; KeyIn[127:120] = key byte 0
// - KeyRy   in   1    KeyIn valid for KeySel when high
// - Dout    out  128  ciphertext; held stable from Done until the next Start
// - Done    out  1    one-cycle pulse when Dout is updated
// - Busy    out  1    high from the cycle after Start is accepted until the cycle Done is high
// - Err     out  1    sticky key-timeout flag; cleared only by Start or Rst
// BEHAVIOUR
// - Reset (Rst=1 at posedge), from any state including mid-encryption:
//   - state <= IDLE; all of Dout, Done, Busy, Err, KeyEn and KeySel become 0.
//   - Any partial result is discarded.
// - FSM states and transitions:
//   - IDLE: on Start=1, st <= Din, rnd <= 0, Err <= 0, go to KEY. Otherwise hold.
//   - KEY: drive KeyEn=1 and KeySel=rnd. On an edge with KeyRy=1:
//     - rnd==0: st <= st ^ KeyIn.
//     - 1..9: st <= MixCol(ShiftRows(SubBytes(st))) ^ KeyIn.
//     - rnd==10: st <= ShiftRows(SubBytes(st)) ^ KeyIn, then go to DONE.
//     - Otherwise rnd <= rnd+1 and stay in KEY.
//     - The wait counter resets on every accepted key.
//   - KEY timeout: KeyRy low for KEY_WAIT consecutive cycles -> Err <= 1, go to IDLE,
//     Dout unchanged, no Done.
//   - DONE: Dout <= st, Done=1 for exactly one cycle, Busy=0, go to IDLE.
// - KeyEn/KeySel are registered; KeySel changes only on a key-accept edge.
// - KeyRy seen while KeyEn=0 is ignored.
// - Latency: with KeyRy constantly high, 11 key cycles plus 1 DONE cycle, so Done rises
//   12 cycles after the Start edge. Each cycle KeyRy is low adds one cycle.
// - Start while Busy=1 is ignored; it is neither queued nor allowed to restart.
// - Start in the DONE cycle is ignored. Start in the cycle after Done is accepted.
// - Simultaneous Rst and Start: Rst wins.
// - SubBytes uses a 16-lane combinational S-box (same FIPS-197 table as the key schedule).
// - MixColumns uses GF(2^8) xtime with polynomial 0x11B, applied per 32-bit column.
// - rnd is 4 bits and never exceeds 10; the design has no wrap-around.
// CONFIGURATION
// - AES_ROUND_DBG_EN defined:
//   - Adds port DbgRnd (out, 4), equal to rnd.
//   - Adds port DbgSt (out, 128), equal to st, so a bench can check each round of the state.
//   - Both ports reset to 0.
// - AES_ROUND_DBG_EN undefined: neither port exists; all other behaviour is identical.
// TESTING
// - FIPS-197 App.B vector, with the key schedule loaded with key 2b7e151628aed2a6abf7158809cf4f3c
//   and KeyRy tied high:
//   - Start with Din=3243f6a8885a308d313198a2e0370734.
//   - Expect Dout=3925841d02dc09fbdc118597196a0b32 and Done exactly 12 cycles after Start.
// - Same key, Din=6bc1bee22e409f96e93d7e117393172a -> Dout=3ad77bb40d7a3660a89ecaf32466ef97.
// - KeyRy low for 3 cycles on each of rounds 0, 5 and 10 -> same ciphertext as the first
//   scenario, and Done at 21 cycles.
// - Start pulsed at cycles 4 and 11 during an encryption -> result is unaffected, only one
//   Done, and Busy stays high throughout.
// - Rst asserted at round 6, then Start with vector B:
//   - Outputs are all 0 the cycle after Rst.
//   - The next run gives the correct ciphertext.
// - KeyRy held low for 15 cycles in round 2 -> Err=1, return to IDLE, no Done, and Dout keeps
//   its previous value. A subsequent Start clears Err.

Source files
------------

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encryption, one round per accepted round key; AES_ROUND_DBG_EN adds DbgRnd/DbgSt.
module aes_cipher_core #(
  parameter int NR       = 10,
  parameter int KEY_WAIT = 15
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [127:0] Din,
  output logic [3:0]   KeySel,
  output logic         KeyEn,
  input  logic [127:0] KeyIn,
  input  logic         KeyRy,
  output logic [127:0] Dout,
  output logic         Done,
  output logic         Busy,
`ifdef AES_ROUND_DBG_EN
  output logic [3:0]   DbgRnd,
  output logic [127:0] DbgSt,
`endif
  output logic         Err
);
  localparam int WW = $clog2(KEY_WAIT + 1);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, KEY, DONE} state_t;
  state_t state, nxt;
  logic [127:0] st, sb, nst;
  logic [3:0] rnd;
  logic [WW-1:0] wcnt;
  logic acc, tmo;
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255-int'(x)) +: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // Byte i sits at row i%4, column i/4; ShiftRows pulls row r from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*(4*((i/4 + i%4) % 4) + i%4) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction
  assign sb  = sub_shift(st);
  assign nst = (rnd == 4'd0 ? st : rnd == 4'(NR) ? sb : mix(sb)) ^ KeyIn;
  assign acc = state == KEY && KeyRy;
  assign tmo = state == KEY && !KeyRy && wcnt == WW'(KEY_WAIT - 1);
  always_ff @(posedge Clk)
    state <= Rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (Start ? KEY : IDLE) :
          state == KEY  ? (acc && rnd == 4'(NR) ? DONE : tmo ? IDLE : KEY) : IDLE;
  always_comb begin
    Busy = state != IDLE;
`ifdef AES_ROUND_DBG_EN
    DbgRnd = rnd;
    DbgSt  = st;
`endif
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st     <= '0;
      rnd    <= '0;
      wcnt   <= '0;
      Dout   <= '0;
      Done   <= 1'b0;
      Err    <= 1'b0;
      KeyEn  <= 1'b0;
      KeySel <= '0;
    end else begin
      Done  <= state == DONE;
      KeyEn <= nxt == KEY;
      if (state == IDLE && Start) begin
        st     <= Din;
        rnd    <= '0;
        wcnt   <= '0;
        Err    <= 1'b0;
        KeySel <= '0;
      end
      if (acc) begin
        st   <= nst;
        wcnt <= '0;
        if (rnd != 4'(NR)) begin
          rnd    <= rnd + 4'd1;
          KeySel <= rnd + 4'd1;
        end
      end else if (state == KEY)
        wcnt <= wcnt + WW'(1);
      if (tmo)
        Err <= 1'b1;
      if (state == DONE)
        Dout <= st;
    end
  end
endmodule

// File: tb/tb_aes_cipher_core.sv
// tb_aes_cipher_core: directed FIPS-197 / SP800-38A vectors with a round-key table standing in for the key schedule.
module tb_aes_cipher_core;
  logic Clk = 1'b0;
  logic Rst, Start, KeyEn, KeyRy, Done, Busy, Err;
  logic [127:0] Din, KeyIn, Dout;
  logic [3:0] KeySel;
  logic [127:0] rk [0:10];
  int checks = 0, errors = 0;
  int lat, bl, dn;
  localparam logic [127:0] PA = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CA = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CB = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  always #5 Clk = ~Clk;
  assign KeyIn = (KeySel <= 4'd10) ? rk[KeySel] : '0;
  aes_cipher_core dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Din(Din), .KeySel(KeySel), .KeyEn(KeyEn),
    .KeyIn(KeyIn), .KeyRy(KeyRy), .Dout(Dout), .Done(Done), .Busy(Busy), .Err(Err)
  );
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Start one block, stall KeyRy for slen cycles on each round set in mask, pulse Start before edges pa+1/pb+1.
  task automatic run(input logic [127:0] din, input logic [15:0] mask, input int slen,
                     input int pa, input int pb, output int n, output int busy_low);
    int sc [16];
    for (int i = 0; i < 16; i++) sc[i] = 0;
    Din = din;
    Start = 1'b1;
    KeyRy = 1'b1;
    step;
    Start = 1'b0;
    Din = ~din;
    n = 0;
    busy_low = Busy ? 0 : 1;
    while (!Done && !Err && n < 100) begin
      Start = (n == pa || n == pb);
      if (KeyEn && mask[KeySel] && sc[KeySel] < slen) begin
        KeyRy = 1'b0;
        sc[KeySel]++;
      end else
        KeyRy = 1'b1;
      step;
      n++;
      if (!Done && !Busy) busy_low++;
    end
    Start = 1'b0;
    KeyRy = 1'b1;
  endtask
  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    Rst = 1'b1; Start = 1'b0; Din = '0; KeyRy = 1'b1;
    step; step;
    Rst = 1'b0;
    chk("rst_dout", Dout, '0);
    chk("rst_done", Done, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", Err, 0);
    chk("rst_keyen", KeyEn, 0);
    chk("rst_keysel", KeySel, 0);
    run(PA, 16'h0000, 0, -1, -1, lat, bl);
    chk("a_dout", Dout, CA);
    chk("a_lat", lat, 12);
    chk("a_busy_run", bl, 0);
    chk("a_busy_done", Busy, 0);
    step;
    chk("a_done_pulse", Done, 0);
    chk("a_dout_hold", Dout, CA);
    run(PB, 16'h0000, 0, -1, -1, lat, bl);
    chk("b_dout", Dout, CB);
    chk("b_lat", lat, 12);
    run(PA, 16'h0421, 3, -1, -1, lat, bl);
    chk("stall_dout", Dout, CA);
    chk("stall_lat", lat, 21);
    chk("stall_busy", bl, 0);
    run(PB, 16'h0000, 0, 3, 10, lat, bl);
    chk("pulse_dout", Dout, CB);
    chk("pulse_lat", lat, 12);
    chk("pulse_busy", bl, 0);
    dn = 0;
    repeat (4) begin step; if (Done) dn++; end
    chk("pulse_one_done", dn, 0);
    chk("pulse_idle", Busy, 0);
    run(PA, 16'h0000, 0, 11, -1, lat, bl);
    chk("donecyc_dout", Dout, CA);
    step;
    chk("donecyc_ignored", Busy, 0);
    Din = PA; Start = 1'b1;
    step;
    Start = 1'b0;
    repeat (7) step;
    chk("mid_busy", Busy, 1);
    Rst = 1'b1;
    step;
    Rst = 1'b0;
    chk("mid_rst_dout", Dout, '0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_keyen", KeyEn, 0);
    chk("mid_rst_keysel", KeySel, 0);
    chk("mid_rst_done", Done, 0);
    Rst = 1'b1; Start = 1'b1; Din = PA;
    step;
    Rst = 1'b0; Start = 1'b0;
    chk("rst_beats_start", Busy, 0);
    run(PB, 16'h0000, 0, -1, -1, lat, bl);
    chk("post_rst_dout", Dout, CB);
    chk("post_rst_lat", lat, 12);
    run(PA, 16'h0004, 15, -1, -1, lat, bl);
    chk("tmo_err", Err, 1);
    chk("tmo_done", Done, 0);
    chk("tmo_dout", Dout, CB);
    chk("tmo_lat", lat, 17);
    chk("tmo_busy", Busy, 0);
    step; step;
    chk("tmo_err_sticky", Err, 1);
    chk("tmo_keyen", KeyEn, 0);
    run(PA, 16'h0000, 0, -1, -1, lat, bl);
    chk("clr_err", Err, 0);
    chk("clr_dout", Dout, CA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
